// File: rtl/div_pkg.sv
// Shared types and constants for the clock-division tick controller.
// Holds the controller state encoding and the divide-ratio clamp.
package div_pkg;

    localparam int CNT_W   = 27;
    localparam int DIV_MIN = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP
    } state_t;

    function automatic logic [CNT_W-1:0] clamp_div(
        input logic [CNT_W-1:0] d
    );
        return (d < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/div_tick_ctrl_if.sv
// Divide-ratio configuration handshake (valid/ready).
// The master offers a ratio; the slave accepts it when ready is high.
interface div_tick_ctrl_if import div_pkg::*; ();

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/div_counter.sv
// Terminal-count counter: counts 0..div-1 while enabled, wraps to 0.
// term flags the last count of the current period.
module div_counter import div_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    logic [CNT_W-1:0] r_cnt;

    assign term = (r_cnt == div - CNT_W'(1));
    assign cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= term ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/div_tick_ctrl.sv
// Run/stop/single-step controller producing a tick enable and slow clock.
// Ratio updates are staged and only take effect on period boundaries.
module div_tick_ctrl import div_pkg::*; #(
    parameter logic [CNT_W-1:0] DEF_DIV = 27'd50_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic            step,
    div_tick_ctrl_if.slave  cfg,
    output logic            tick,
    output logic            clk_out,
    output logic            running
);

    state_t           r_state;
    state_t           w_next;
    logic             r_tick;
    logic             r_clk_out;
    logic             r_pend_vld;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cfg_d;
    logic             w_term;
    logic             w_active;
    logic             w_xfer;
    logic             w_fire;
    logic             w_to_idle;

    assign w_active  = (r_state != IDLE);
    assign w_xfer    = cfg.cfg_valid && !r_pend_vld;
    assign w_cfg_d   = clamp_div(cfg.cfg_div);
    assign w_fire    = w_active && w_term && !stop;
    assign w_to_idle = w_active && (stop || (r_state == STEP && w_term));

    div_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_active),
        .clr   (!w_active || stop),
        .div   (r_div),
        .cnt   (w_cnt),
        .term  (w_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (stop)       w_next = IDLE;
                else if (start) w_next = RUN;
                else if (step)  w_next = STEP;
            end
            RUN: begin
                if (stop) w_next = IDLE;
            end
            STEP: begin
                if (stop || w_term) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // A ratio arriving as we drop back to IDLE is applied directly,
    // otherwise it would sit pending with nothing to retire it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick     <= 1'b0;
            r_clk_out  <= 1'b0;
            r_div      <= DEF_DIV;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_tick <= w_fire;
            if (w_fire) r_clk_out <= ~r_clk_out;
            if (!w_active) begin
                if (w_xfer) r_div <= w_cfg_d;
            end else if (w_to_idle) begin
                if (w_xfer)          r_div <= w_cfg_d;
                else if (r_pend_vld) r_div <= r_pend;
                r_pend_vld <= 1'b0;
            end else begin
                if (w_term && r_pend_vld) begin
                    r_div      <= r_pend;
                    r_pend_vld <= 1'b0;
                end
                if (w_xfer) begin
                    r_pend     <= w_cfg_d;
                    r_pend_vld <= 1'b1;
                end
            end
        end
    end

    assign cfg.cfg_ready = !r_pend_vld;
    assign tick          = r_tick;
    assign clk_out       = r_clk_out;
    assign running       = w_active;

    cnt_in_range: assert property (
        @(posedge clk) disable iff (!rst_n) w_cnt < r_div
    );

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Bench for div_tick_ctrl: vector table, directed corners, random vs model.
// The model tracks elapsed cycles per period and a queue of pending ratios.
module tb_div_tick_ctrl;
    import div_pkg::*;

    localparam logic [CNT_W-1:0] DEF = 27'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic step = 1'b0;
    logic tick, clk_out, running;

    div_tick_ctrl_if cfg ();

    div_tick_ctrl #(.DEF_DIV(DEF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .cfg     (cfg.slave),
        .tick    (tick),
        .clk_out (clk_out),
        .running (running)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: 0 idle, 1 run, 2 single step
    int m_act, m_el, m_div;
    int m_pend[$];
    bit m_tick, m_clk;

    function automatic int clampi(int d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    task automatic m_reset();
        m_act = 0; m_el = 0; m_div = int'(DEF);
        m_pend.delete(); m_tick = 0; m_clk = 0;
    endtask

    task automatic m_step(bit st, bit sp, bit stp, bit v, int d);
        bit xfer;
        int cd;
        xfer = v && (m_pend.size() == 0);
        cd = clampi(d);
        m_tick = 0;
        if (m_act == 0) begin
            if (xfer) m_div = cd;
            if (!sp) begin
                if (st) begin m_act = 1; m_el = 0; end
                else if (stp) begin m_act = 2; m_el = 0; end
            end
        end else begin
            m_el++;
            if (sp) begin
                if (m_pend.size() != 0) m_div = m_pend.pop_front();
                if (xfer) m_div = cd;
                m_act = 0; m_el = 0;
            end else begin
                if (m_el == m_div) begin
                    m_tick = 1; m_clk = !m_clk; m_el = 0;
                    if (m_pend.size() != 0) m_div = m_pend.pop_front();
                    if (m_act == 2) begin
                        m_act = 0;
                        if (xfer) begin m_div = cd; xfer = 0; end
                    end
                end
                if (xfer) m_pend.push_back(cd);
            end
        end
    endtask

    task automatic cyc(bit st, bit sp, bit stp, bit v = 0, int d = 0);
        @(negedge clk);
        start = st; stop = sp; step = stp;
        cfg.cfg_valid = v; cfg.cfg_div = d[CNT_W-1:0];
        m_step(st, sp, stp, v, d);
        @(posedge clk);
        #1;
        check("tick", tick, m_tick);
        check("clk_out", clk_out, m_clk);
        check("running", running, m_act != 0);
        check("cfg_ready", cfg.cfg_ready, m_pend.size() == 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_clk_out"}, clk_out, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_cfg_ready"}, cfg.cfg_ready, 1);
    endtask

    typedef struct {
        bit st;
        bit e_tick;
        bit e_clk;
        bit e_run;
        bit e_rdy;
    } vec_t;

    vec_t vt[13];

    initial begin
        bit c_save;
        int got;
        for (int i = 0; i < 13; i++) begin
            vt[i].st = (i == 0);
            vt[i].e_tick = (i == 4) || (i == 8) || (i == 12);
            vt[i].e_clk = (i >= 4 && i < 8) || (i == 12);
            vt[i].e_run = 1;
            vt[i].e_rdy = 1;
        end

        m_reset();
        cfg.cfg_valid = 0;
        cfg.cfg_div = '0;
        #2 rst_n = 0;
        #10;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1;

        // Start with DEF_DIV=4: ticks after 4, 8, 12 edges
        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].st, 0, 0);
            check("vec_tick", tick, vt[i].e_tick);
            check("vec_clk", clk_out, vt[i].e_clk);
            check("vec_run", running, vt[i].e_run);
            check("vec_rdy", cfg.cfg_ready, vt[i].e_rdy);
        end

        // Ratio 6 offered at cycle 5 of a D=4 run
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        for (int n = 1; n <= 20; n++) begin
            cyc(0, 0, 0, n == 5, 6);
            check("upd_tick", tick, (n == 4) || (n == 8) || (n == 14) || (n == 20));
            check("upd_ready", cfg.cfg_ready, !(n >= 5 && n < 8));
        end

        // Single step with D=3
        cyc(0, 1, 0);
        cyc(0, 0, 0, 1, 3);
        cyc(0, 0, 1);
        for (int n = 1; n <= 6; n++) begin
            cyc(0, 0, 0);
            check("step_tick", tick, n == 3);
            check("step_running", running, n < 3);
        end

        // Stop in the terminal-count cycle, then a full restart
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        c_save = m_clk;
        cyc(0, 1, 0);
        check("stopterm_tick", tick, 0);
        check("stopterm_run", running, 0);
        check("stopterm_clk", clk_out, c_save);
        cyc(1, 0, 0);
        got = 99;
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0);
            if (tick) begin got = k; break; end
        end
        check("restart_period", got, 3);

        // Ratios 0 and 1 clamp to 2
        cyc(0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 0);
        for (int n = 1; n <= 6; n++) begin
            cyc(0, 0, 0);
            check("clamp_tick", tick, (n % 2) == 0);
        end

        // Reset mid-period with a pending ratio
        cyc(0, 0, 0, 1, 7);
        check("pend_ready_low", cfg.cfg_ready, 0);
        cyc(0, 0, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check_reset_outputs("async_rst");
        m_reset();
        @(negedge clk) rst_n = 1;
        cyc(1, 0, 0);
        for (int n = 1; n <= 8; n++) begin
            cyc(0, 0, 0);
            check("post_rst_tick", tick, (n == 4) || (n == 8));
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 4) == 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 6)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
